// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl shared types: FSM state encoding, wait-counter width
// and the idle (inactive) levels of the SRAM and buffer control pins.
package sram_ctrl_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    RD_CAP,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  localparam logic CE_N_OFF     = 1'b1;
  localparam logic OE_N_OFF     = 1'b1;
  localparam logic WE_N_OFF     = 1'b1;
  localparam logic BUF_WE_N_OFF = 1'b1;
  localparam logic BUF_OE_OFF   = 1'b0;
  localparam logic LANE_N_ON    = 1'b0;

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl request/response bus: req_valid/req_ready handshake with
// we/addr/wdata (+ req_be when SRAM_CTRL_BYTE_EN), rsp_valid/rsp_rdata.
interface sram_ctrl_if #(
  parameter int N      = 16,
  parameter int ADDR_W = 20
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [N-1:0]      req_wdata;
`ifdef SRAM_CTRL_BYTE_EN
  logic [1:0]        req_be;
`endif
  logic              rsp_valid;
  logic [N-1:0]      rsp_rdata;

  modport master (
    input  req_ready, rsp_valid, rsp_rdata,
`ifdef SRAM_CTRL_BYTE_EN
    output req_be,
`endif
    output req_valid, req_we, req_addr, req_wdata
  );

  modport slave (
    output req_ready, rsp_valid, rsp_rdata,
`ifdef SRAM_CTRL_BYTE_EN
    input  req_be,
`endif
    input  req_valid, req_we, req_addr, req_wdata
  );

endinterface

// File: rtl/sram_ctrl.sv
// Single-word SRAM access sequencer feeding a registered DQ buffer.
// Ports: Clk, Reset_n, bus (sram_ctrl_if.slave), SRAM_* pins,
// buf_we_n/buf_oe/Data_write to the buffer, Data_read from it.
// Option: SRAM_CTRL_BYTE_EN adds req_be and drives UB_N/LB_N on writes.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int N           = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              buf_we_n,
  output logic              buf_oe,
  output logic [N-1:0]      Data_write,
  input  logic [N-1:0]      Data_read
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be 0..7");
  end

  localparam logic [WAIT_W-1:0] WAIT_LD =
    WAIT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [N-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              bwe_n_q, bwe_n_d;
  logic              boe_q, boe_d;

  logic [1:0] req_be;
`ifdef SRAM_CTRL_BYTE_EN
  assign req_be = bus.req_be;
`else
  assign req_be = 2'b11;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = req_be;
          cnt_d   = WAIT_LD;
          state_d = bus.req_we ? WR_SETUP
                               : RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_CAP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = Data_read;
        state_d     = IDLE;
      end
      WR_SETUP: begin
        cnt_d   = WAIT_LD;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are decoded from the next state so every output is a flop
  // that changes on the same edge as the state it belongs to.
  always_comb begin
    ready_d = 1'b0;
    ce_n_d  = CE_N_OFF;
    oe_n_d  = OE_N_OFF;
    we_n_d  = WE_N_OFF;
    bwe_n_d = BUF_WE_N_OFF;
    boe_d   = BUF_OE_OFF;
    ub_n_d  = LANE_N_ON;
    lb_n_d  = LANE_N_ON;
    unique case (state_d)
      IDLE: ready_d = 1'b1;
      RD_ACCESS: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      RD_CAP: ce_n_d = 1'b0;
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        ce_n_d  = 1'b0;
        we_n_d  = (state_d != WR_PULSE);
        bwe_n_d = 1'b0;
        boe_d   = 1'b1;
`ifdef SRAM_CTRL_BYTE_EN
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
`endif
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 2'b11;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ce_n_q      <= CE_N_OFF;
      oe_n_q      <= OE_N_OFF;
      we_n_q      <= WE_N_OFF;
      ub_n_q      <= LANE_N_ON;
      lb_n_q      <= LANE_N_ON;
      bwe_n_q     <= BUF_WE_N_OFF;
      boe_q       <= BUF_OE_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      bwe_n_q     <= bwe_n_d;
      boe_q       <= boe_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign SRAM_ADDR     = addr_q;
  assign SRAM_CE_N     = ce_n_q;
  assign SRAM_OE_N     = oe_n_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_UB_N     = ub_n_q;
  assign SRAM_LB_N     = lb_n_q;
  assign buf_we_n      = bwe_n_q;
  assign buf_oe        = boe_q;
  assign Data_write    = wdata_q;

  a_no_contention: assert property (
    @(posedge Clk) disable iff (!Reset_n)
    !(!oe_n_q && !bwe_n_q && boe_q));

  a_we_needs_drive: assert property (
    @(posedge Clk) disable iff (!Reset_n)
    !we_n_q |-> (!bwe_n_q && boe_q));

endmodule

// File: tb/tb_sram_ctrl.sv
// sram_ctrl bench: buffer + SRAM models, reference memory and
// a response scoreboard checked by an independent monitor.
module tb_sram_ctrl;

  localparam int W = 1;

  typedef struct {
    logic [15:0] data;
    int          acc;
  } sb_t;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  sram_ctrl_if #(.N(16), .ADDR_W(20)) bus ();

  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic        SRAM_UB_N, SRAM_LB_N;
  logic        buf_we_n, buf_oe;
  logic [15:0] Data_write, Data_read;

  sram_ctrl #(.N(16), .ADDR_W(20), .WAIT_CYCLES(W)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bus        (bus),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N),
    .buf_we_n   (buf_we_n),
    .buf_oe     (buf_oe),
    .Data_write (Data_write),
    .Data_read  (Data_read)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h",
               name, act, exp);
    end
  endtask

  // registered tristate buffer and asynchronous SRAM
  logic        drv;
  logic [15:0] bdata;
  logic [15:0] dq;
  logic [15:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drv       <= 1'b0;
      bdata     <= '0;
      Data_read <= '0;
    end else begin
      drv       <= !buf_we_n && buf_oe;
      bdata     <= Data_write;
      Data_read <= dq;
    end
  end

  always_comb begin
    dq = 'x;
    if (drv)
      dq = bdata;
    else if (!SRAM_CE_N && !SRAM_OE_N)
      dq = mem[SRAM_ADDR[7:0]];
  end

  function automatic logic [15:0] lane_wr(
    input logic [15:0] o, input logic [15:0] n,
    input logic ub_n, input logic lb_n);
    lane_wr = o;
    if (!ub_n) lane_wr[15:8] = n[15:8];
    if (!lb_n) lane_wr[7:0]  = n[7:0];
  endfunction

  always @(posedge Clk) begin
    if (pre_en)
      mem[pre_a] <= pre_d;
    else if (Reset_n && !SRAM_CE_N && !SRAM_WE_N)
      mem[SRAM_ADDR[7:0]] <= lane_wr(mem[SRAM_ADDR[7:0]],
                               dq, SRAM_UB_N, SRAM_LB_N);
  end

  // reference model
  logic [15:0] ref_mem [logic [19:0]];
  sb_t sb_q[$];

  always @(negedge Clk) begin
    if (Reset_n && bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("rsp_data", bus.rsp_rdata, e.data);
        chk("rsp_latency", cyc - e.acc, W + 3);
      end
    end
  end

  task automatic preload(input logic [7:0] a,
                         input logic [15:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    @(posedge Clk);
    #1 pre_en = 1'b0;
    ref_mem[{12'h0, a}] = d;
  endtask

  task automatic accept(input logic we,
                        input logic [19:0] a,
                        input logic [15:0] d,
                        input logic [1:0] be,
                        input bit keep,
                        output int acc);
    int n;
    logic [1:0] eb;
    logic [15:0] old, mask;
    sb_t e;
    n  = 0;
    eb = be;
`ifndef SRAM_CTRL_BYTE_EN
    eb = 2'b11;
`endif
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef SRAM_CTRL_BYTE_EN
    bus.req_be    = be;
`endif
    while (!bus.req_ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("accept_bound", 32'(n < 100), 1);
    acc = cyc;
    if (we) begin
      old  = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
      mask = {{8{eb[1]}}, {8{eb[0]}}};
      ref_mem[a] = (old & ~mask) | (d & mask);
    end else begin
      e.data = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
      e.acc  = cyc;
      sb_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic observe(input logic we,
                         input logic [15:0] d,
                         input logic [1:0] be);
    int busy, wlow, olow, hold, bad_dq, bad_ln;
    bit seen;
    logic eu, el;
    busy = 0; wlow = 0; olow = 0;
    hold = 0; bad_dq = 0; bad_ln = 0;
    seen = 0;
    eu = 1'b0;
    el = 1'b0;
`ifdef SRAM_CTRL_BYTE_EN
    if (we) begin
      eu = ~be[1];
      el = ~be[0];
    end
`endif
    @(negedge Clk);
    while (!bus.req_ready && busy < 50) begin
      busy++;
      if (!SRAM_WE_N) begin
        wlow++;
        seen = 1;
        if (dq !== d) bad_dq++;
      end else if (seen) begin
        hold++;
        if (dq !== d) bad_dq++;
      end
      if (!SRAM_OE_N) olow++;
      if (SRAM_UB_N !== eu || SRAM_LB_N !== el)
        bad_ln++;
      @(negedge Clk);
    end
    if (we) begin
      chk("wr_busy", busy, W + 3);
      chk("wr_we_low", wlow, W + 1);
      chk("wr_hold", hold, 1);
      chk("wr_dq", bad_dq, 0);
      chk("wr_oe_low", olow, 0);
    end else begin
      chk("rd_busy", busy, W + 2);
      chk("rd_oe_low", olow, W + 1);
      chk("rd_we_low", wlow, 0);
    end
    chk("lanes", bad_ln, 0);
  endtask

  initial begin
    int acc1, acc2, quiet, n;
    bit written [16];
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef SRAM_CTRL_BYTE_EN
    bus.req_be    = 2'b11;
`endif
    foreach (written[i]) written[i] = 1'b0;

    #1 Reset_n = 1'b0;
    #2;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dwrite", Data_write, 0);
    chk("rst_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
    chk("rst_lanes", {SRAM_UB_N, SRAM_LB_N}, 2'b00);
    chk("rst_buf", {buf_we_n, buf_oe}, 2'b10);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    quiet = 0;
    repeat (5) begin
      @(negedge Clk);
      if (bus.rsp_valid || !bus.req_ready || !SRAM_CE_N ||
          !SRAM_OE_N || !SRAM_WE_N || buf_oe)
        quiet++;
    end
    chk("idle_quiet", quiet, 0);

    accept(1'b1, 20'h00012, 16'hBEEF, 2'b11, 0, acc1);
    written[2] = 1'b1;
    observe(1'b1, 16'hBEEF, 2'b11);
    chk("mem_0x12", mem[8'h12], 16'hBEEF);
    accept(1'b0, 20'h00012, 16'h0, 2'b11, 0, acc1);
    observe(1'b0, 16'h0, 2'b11);

    preload(8'h01, 16'h1234);
    accept(1'b0, 20'h00001, 16'h0, 2'b11, 1, acc1);
    accept(1'b1, 20'h00002, 16'h5678, 2'b11, 0, acc2);
    chk("b2b_gap", acc2 - acc1, W + 3);
    observe(1'b1, 16'h5678, 2'b11);
    chk("mem_0x2", mem[8'h02], 16'h5678);
    accept(1'b0, 20'h00002, 16'h0, 2'b11, 0, acc1);
    observe(1'b0, 16'h0, 2'b11);

    accept(1'b1, 20'h00040, 16'hCAFE, 2'b11, 0, acc1);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (SRAM_WE_N && n < 20);
    chk("rst_reach_pulse", SRAM_WE_N, 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
    chk("mid_rst_buf", {buf_we_n, buf_oe}, 2'b10);
    chk("mid_rst_dq", drv, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_rsp", bus.rsp_valid, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    accept(1'b1, 20'h00013, 16'hA5C3, 2'b11, 0, acc1);
    written[3] = 1'b1;
    observe(1'b1, 16'hA5C3, 2'b11);
    accept(1'b0, 20'h00013, 16'h0, 2'b11, 0, acc1);
    observe(1'b0, 16'h0, 2'b11);

`ifdef SRAM_CTRL_BYTE_EN
    preload(8'h30, 16'h1111);
    accept(1'b1, 20'h00030, 16'hAB00, 2'b10, 0, acc1);
    observe(1'b1, 16'hAB00, 2'b10);
    chk("be_mem", mem[8'h30], 16'hAB11);
    accept(1'b0, 20'h00030, 16'h0, 2'b11, 0, acc1);
    observe(1'b0, 16'h0, 2'b11);
`endif

    for (int i = 0; i < 40; i++) begin
      int k;
      bit rd;
      logic [1:0]  be;
      logic [15:0] d;
      k  = $urandom_range(0, 15);
      rd = ($urandom_range(0, 1) == 1) && written[k];
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      if (!written[k]) be = 2'b11;
      if (rd) begin
        accept(1'b0, 20'h10 + 20'(k), 16'h0, 2'b11, 0, acc1);
        observe(1'b0, 16'h0, 2'b11);
      end else begin
        accept(1'b1, 20'h10 + 20'(k), d, be, 0, acc1);
        written[k] = 1'b1;
        observe(1'b1, d, be);
      end
    end

    repeat (10) @(negedge Clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
